// File: rtl/key_input_pio_pkg.sv
// key_input_pio_pkg: shared constants, edge-type enum and edge helper
// for the key_input_pio push-button/switch peripheral.
package key_input_pio_pkg;

  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd1;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd2;
  localparam logic [1:0] ADDR_RAW          = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_t;

  // True when the transition prev -> cur matches the selected edge kind.
  function automatic logic edge_event(input logic cur, input logic prev,
                                      input edge_type_t kind);
    logic hit;
    case (kind)
      EDGE_RISE: hit = cur & ~prev;
      EDGE_FALL: hit = ~cur & prev;
      default:   hit = cur ^ prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/key_input_pio_if.sv
// key_input_pio_if: Avalon-MM slave bus bundle for key_input_pio.
// The CPU/interconnect side uses the master modport, the peripheral the slave.
interface key_input_pio_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/key_input_sync_debounce.sv
// key_input_sync_debounce: one input bit - two-flop synchroniser followed by
// an optional debounce filter. Debounce is compiled in only when the macro
// KEY_INPUT_PIO_DEBOUNCE_EN is defined; otherwise the stable level is the
// second synchroniser flop itself.
module key_input_sync_debounce #(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic raw_o,
  output logic stable_o
);

  logic sync1_q;
  logic sync2_q;

  // Two-stage synchroniser for the asynchronous pin, parked at the idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  assign raw_o = sync2_q;

`ifdef KEY_INPUT_PIO_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;

  // Count consecutive cycles the synchronised level disagrees with the
  // accepted level; any return to agreement restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Debounce state; reset drops any partially counted disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= IDLE_LEVEL;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`else
  assign stable_o = sync2_q;
`endif

endmodule

// File: rtl/key_input_pio.sv
// key_input_pio: Avalon-MM input port with per-bit synchronise/debounce,
// sticky edge capture, interrupt mask and level irq.
// Optional debounce is enabled by defining KEY_INPUT_PIO_DEBOUNCE_EN.
module key_input_pio
  import key_input_pio_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter int   EDGE_TYPE       = 1,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  key_input_pio_if.slave   bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] EDGE_BITS = EDGE_TYPE[1:0];
  localparam edge_type_t EDGE_SEL  = edge_type_t'(EDGE_BITS);

  logic [WIDTH-1:0] raw_w;
  logic [WIDTH-1:0] stable_w;
  logic [WIDTH-1:0] stable_prev_q;
  logic [WIDTH-1:0] edge_evt;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] cap_q;
  logic [WIDTH-1:0] cap_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    key_input_sync_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .pin_i    (in_port[g]),
      .raw_o    (raw_w[g]),
      .stable_o (stable_w[g])
    );
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  // Compare the accepted level with its one-cycle-old copy for edge events.
  always_comb begin
    edge_evt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_evt[i] = edge_event(stable_w[i], stable_prev_q[i], EDGE_SEL);
    end
  end

  // Next mask and capture; a new event beats a simultaneous clear.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && (bus.address == ADDR_IRQ_MASK)) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && (bus.address == ADDR_EDGE_CAPTURE)) begin
      clr = bus.writedata[WIDTH-1:0];
    end
    cap_d = (cap_q & ~clr) | edge_evt;
  end

  // Read mux; readdata is reloaded every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:         readdata_d[WIDTH-1:0] = stable_w;
      ADDR_IRQ_MASK:     readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE_CAPTURE: readdata_d[WIDTH-1:0] = cap_q;
      default:           readdata_d[WIDTH-1:0] = raw_w;
    endcase
  end

  // Register state; idle-level edge history avoids a spurious post-reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_prev_q <= {WIDTH{IDLE_LEVEL}};
      mask_q        <= '0;
      cap_q         <= '0;
      readdata_q    <= '0;
    end else begin
      stable_prev_q <= stable_w;
      mask_q        <= mask_d;
      cap_q         <= cap_d;
      readdata_q    <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(cap_q & mask_q);

endmodule

// File: doc/key_input_pio.md
# key_input_pio

Parametrised Avalon-MM read/interrupt peripheral for the board push-buttons and switches of the VGA game platform, replacing the fixed 4-bit input port. Each input bit is synchronised, optionally debounced, and edge-detected into a sticky capture register. An interrupt is raised for unmasked captured edges. The block sits on the Nios II system interconnect next to the VGA controller slaves.

## Interface
- WIDTH, 4: input bit count, 1..32.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a new level is accepted; must be ≥2; used only with debounce compiled in.
- EDGE_TYPE, 1: edge captured. 0 = rising, 1 = falling (button press), 2 = any.
- IDLE_LEVEL, 1: reset value of the synchroniser and stable registers. A single value applies to all bits.
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; valid only with chipselect.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous button/switch pins.
- readdata  out  32  registered read data; bits above WIDTH read 0.
- irq  out  1  level interrupt.

## Operation
- Register map:
  - 0 DATA: stable (debounced) level, read-only.
  - 1 IRQ_MASK: read/write; 1 enables the bit.
  - 2 EDGE_CAPTURE: read; writing 1 clears the bit, writing 0 has no effect.
  - 3 RAW: synchroniser output, read-only.
- Writes to addresses 0 and 3 are ignored.
- Synchroniser: two flops per bit (sync1, sync2), reset to IDLE_LEVEL.
- Debounce, per bit:
  - If sync2 == stable, then cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, then stable <= sync2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles resets the count and is never accepted.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Edge detect: stable_d <= stable. An event occurs when stable differs from stable_d in the direction selected by EDGE_TYPE.
- EDGE_CAPTURE[i]:
  - Set on an event.
  - Cleared by a write of 1.
  - If set and clear occur in the same cycle, set wins.
- irq = |(EDGE_CAPTURE & IRQ_MASK), driven from registers, with no combinational path from the bus.
- Reset values:
  - readdata = 0, irq = 0, IRQ_MASK = 0, EDGE_CAPTURE = 0, cnt = 0.
  - sync1, sync2, stable and stable_d = IDLE_LEVEL, so no spurious edge appears after reset.
- Reset asserted mid-debounce discards the pending count.

## Timing
- Read latency is 1 cycle. readdata is reloaded every clock from the selected register, whether or not chipselect is asserted.
- Writes take effect at the clock edge where chipselect=1 and write_n=0. Readback is visible on readdata 2 edges after the write edge.
- Without debounce:
  - in_port change → RAW and DATA updated after 2 edges.
  - EDGE_CAPTURE set after 3 edges.
  - irq asserted after 3 edges, if the bit is masked in.
- With debounce: DATA updates DEBOUNCE_CYCLES edges after sync2 changes, and EDGE_CAPTURE/irq follow 1 edge later.
- irq deasserts on the edge that clears the last unmasked capture bit, or on the edge that clears its mask bit.

## Configuration
- KEY_INPUT_PIO_DEBOUNCE_EN defined: debounce counters are instantiated as described above.
- Not defined: stable <= sync2 every cycle, there are no counters, and DEBOUNCE_CYCLES is ignored. This suits slide switches and simulation speed.

## Structure
- Package key_input_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQ_MASK=1, ADDR_EDGE_CAPTURE=2, ADDR_RAW=3.
  - enum edge_type_t {EDGE_RISE, EDGE_FALL, EDGE_ANY}.
- Sub-module key_input_sync_debounce: one bit of synchroniser, debounce counter and stable register. It is generated WIDTH times in the top level.
- The top level holds the bus decode, mask, capture logic and irq.

## Test plan
Bench settings: WIDTH=4, EDGE_TYPE=1, IDLE_LEVEL=1, DEBOUNCE_CYCLES=8.
- Reset then read each of the 4 addresses → DATA=0xF, RAW=0xF, mask=0, capture=0, irq=0.
- in_port 0xF→0xE held 20 cycles, no debounce:
  - RAW=0xE after 2 edges.
  - EDGE_CAPTURE=0x1 after 3 edges.
  - irq stays 0 while mask=0.
- Debounce enabled: bit 0 low for 5 cycles then high → DATA stays 0xF and capture stays 0. Bit 0 then held low for 8 cycles after sync → DATA=0xE and capture=0x1.
- Write mask=0x1 with capture=0x1 → irq=1. Then write 0x1 to address 2 → capture=0, irq=0 on that edge.
- Clear write to bit 0 in the same cycle as a new falling edge on bit 0 → capture bit 0 remains 1.
- Assert reset while bit 2 is mid-debounce (cnt=5) → after release DATA=0xF and no capture occurs, even with in_port=0xB held for 7 more cycles.
